// File: rtl/dg_pkg.sv
// Shared types and sizing helpers for the digital loop controller.
package dg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACQ    = 2'd2
    } dg_state_e;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_LOOP     = 2'd1,
        MODE_FORCE_ON = 2'd2,
        MODE_LOOP_INV = 2'd3
    } dg_mode_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dg_delay_line.sv
// Fixed-length 1-bit shift register modelling loop delay and comparator resynchronisation.
module dg_delay_line #(
    parameter int unsigned DELAY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DELAY-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DELAY-1];

endmodule

// File: rtl/dg_loop_ctrl.sv
// Digital loop controller: delays the comparator decision, drives cap-bank feedback and
// converts the ones count of a 2^OSR_LOG2-sample window into a WIDTH-bit code.
module dg_loop_ctrl
    import dg_pkg::*;
#(
    parameter int unsigned DELAY      = 2,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned OSR_LOG2   = 4,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [1:0]       mode,
    input  logic             ctrl,
    output logic             enable,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned WIN      = 1 << OSR_LOG2;
    localparam int unsigned ONES_W   = OSR_LOG2 + 1;
    localparam int unsigned SAMP_W   = cnt_width(WIN - 1);
    localparam int unsigned SETTLE_W = cnt_width(SETTLE_CYC - 1);
    localparam int unsigned SHIFT    = (OSR_LOG2 >= WIDTH) ? (OSR_LOG2 - WIDTH) : 0;

    localparam logic [SAMP_W-1:0]   SAMP_LAST   = SAMP_W'(WIN - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [ONES_W-1:0]   CODE_MAX    = ONES_W'((1 << WIDTH) - 1);

    if (OSR_LOG2 < WIDTH) begin : g_bad_osr
        $error("dg_loop_ctrl: OSR_LOG2 must be >= WIDTH");
    end
    if (DELAY < 1) begin : g_bad_delay
        $error("dg_loop_ctrl: DELAY must be >= 1");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("dg_loop_ctrl: SETTLE_CYC must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("dg_loop_ctrl: WIDTH must be >= 1");
    end

    logic d;

    dg_delay_line #(
        .DELAY (DELAY)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ctrl),
        .dout  (d)
    );

    dg_state_e           state_q, state_d;
    dg_mode_e            mode_q, mode_d;
    logic                cont_q, cont_d;
    logic                start_pend_q, start_pend_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SAMP_W-1:0]   samp_q, samp_d;
    logic [ONES_W-1:0]   ones_q, ones_d;

    logic                enable_d;
    logic [WIDTH-1:0]    out_d;
    logic                out_valid_d;
    logic                overrun_d;
    logic                busy_d;

    logic                new_result;
    logic [ONES_W-1:0]   ones_sum;
    logic [ONES_W-1:0]   ones_shr;
    logic [WIDTH-1:0]    code;

    // Window total including the sample arriving this cycle, scaled and saturated.
    always_comb begin
        ones_sum = ones_q + ONES_W'(d);
        ones_shr = ones_sum >> SHIFT;
        code     = (ones_shr > CODE_MAX) ? {WIDTH{1'b1}} : WIDTH'(ones_shr);
    end

    // Next-state, counters, handshake and feedback.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cont_d       = cont_q;
        start_pend_d = 1'b0;
        settle_d     = settle_q;
        samp_d       = samp_q;
        ones_d       = ones_q;
        out_d        = out;
        out_valid_d  = out_valid;
        overrun_d    = overrun;
        new_result   = 1'b0;
        enable_d     = 1'b0;
        busy_d       = 1'b0;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Start is captured one cycle ahead of SETTLE; a stop in between cancels it.
                if (start_pend_q) begin
                    if (!stop) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_INIT;
                    end
                end else if (start && !stop) begin
                    start_pend_d = 1'b1;
                    mode_d       = dg_mode_e'(mode);
                    cont_d       = cont;
                    overrun_d    = 1'b0;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (settle_q == '0) begin
                    state_d = ACQ;
                    ones_d  = '0;
                    samp_d  = '0;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ACQ: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (samp_q == SAMP_LAST) begin
                    new_result = 1'b1;
                    ones_d     = '0;
                    samp_d     = '0;
                    state_d    = cont_q ? ACQ : IDLE;
                end else begin
                    ones_d = ones_sum;
                    samp_d = samp_q + SAMP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_result) begin
            if (!out_valid || out_ready) begin
                out_d       = code;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);

        if (busy_d) begin
            case (mode_q)
                MODE_LOOP:     enable_d = d;
                MODE_FORCE_ON: enable_d = 1'b1;
                MODE_LOOP_INV: enable_d = ~d;
                default:       enable_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= MODE_OFF;
            cont_q       <= 1'b0;
            start_pend_q <= 1'b0;
            settle_q     <= '0;
            samp_q       <= '0;
            ones_q       <= '0;
            enable       <= 1'b0;
            out          <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cont_q       <= cont_d;
            start_pend_q <= start_pend_d;
            settle_q     <= settle_d;
            samp_q       <= samp_d;
            ones_q       <= ones_d;
            enable       <= enable_d;
            out          <= out_d;
            out_valid    <= out_valid_d;
            overrun      <= overrun_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_dg_loop_ctrl.sv
// Randomised self-checking bench for dg_loop_ctrl against a window-level reference model.
module tb_dg_loop_ctrl;

    localparam int unsigned DELAY      = 2;
    localparam int unsigned WIDTH      = 4;
    localparam int unsigned OSR_LOG2   = 4;
    localparam int unsigned SETTLE_CYC = 3;
    localparam int          N          = 1 << OSR_LOG2;
    localparam int          LAT        = 1 + SETTLE_CYC + N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, cont, ctrl, out_ready;
    logic [1:0]       mode;
    logic             enable, out_valid, overrun, busy;
    logic [WIDTH-1:0] out;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic ctrl_h [0:16383];

    dg_loop_ctrl #(
        .DELAY      (DELAY),
        .WIDTH      (WIDTH),
        .OSR_LOG2   (OSR_LOG2),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .mode      (mode),
        .ctrl      (ctrl),
        .enable    (enable),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ctrl_h[k] is the ctrl value sampled by rising edge number k.
    always @(posedge clk) begin
        ctrl_h[cyc] = ctrl;
        cyc = cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_en(input logic [1:0] m, input logic dv);
        case (m)
            2'd0:    return 1'b0;
            2'd1:    return dv;
            2'd2:    return 1'b1;
            default: return ~dv;
        endcase
    endfunction

    // Code for the window whose last sample is taken at edge r.
    function automatic logic [WIDTH-1:0] exp_code(input int r);
        int ones = 0;
        int c;
        for (int k = r - N + 1; k <= r; k++) ones += int'(ctrl_h[k - DELAY]);
        c = ones >> (OSR_LOG2 - WIDTH);
        if (c > (1 << WIDTH) - 1) c = (1 << WIDTH) - 1;
        return WIDTH'(c);
    endfunction

    function automatic logic next_ctrl(input int pat);
        case (pat)
            0:       return 1'b1;
            1:       return ~ctrl;
            2:       return 1'($urandom % 2);
            default: return 1'b0;
        endcase
    endfunction

    // Single-shot window with per-cycle busy/enable/out_valid checks; returns observed code.
    task automatic run_window(input logic [1:0] m, input int pat, input bit noise,
                              output logic [WIDTH-1:0] got);
        int s, e, r;
        logic eb, ee;
        logic [WIDTH-1:0] ec;
        cont = 1'b0; mode = m; out_ready = 1'b0; start = 1'b1;
        ctrl = next_ctrl(pat);
        tick();
        s = cyc - 1;
        r = s + LAT;
        start = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            ctrl = next_ctrl(pat);
            if (noise && i == 8) begin
                start = 1'b1; mode = ~m; cont = 1'b1;
            end
            tick();
            e = cyc - 1;
            start = 1'b0; mode = m; cont = 1'b0;
            eb = (e >= s + 1) && (e <= r - 1);
            ee = eb ? exp_en(m, ctrl_h[e - DELAY]) : 1'b0;
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL run_busy edge=%0d got=%0b exp=%0b", e - s, busy, eb);
            end
            checks++;
            if (enable !== ee) begin
                failures++;
                $display("FAIL run_enable edge=%0d mode=%0d got=%0b exp=%0b", e - s, m, enable, ee);
            end
            if (e < r) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL run_early_valid edge=%0d got=%0b exp=0", e - s, out_valid);
                end
            end
        end
        ec = exp_code(r);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL run_valid_rise edge=%0d got=%0b exp=1", LAT, out_valid);
        end
        checks++;
        if (out !== ec) begin
            failures++;
            $display("FAIL run_code mode=%0d pat=%0d got=%0d exp=%0d", m, pat, out, ec);
        end
        got = out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL run_consume got valid=%0b busy=%0b exp valid=0 busy=0", out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; mode = 2'd0;
        ctrl = 1'b1; out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%0b exp=0", enable); end
        checks++;
        if (out !== '0) begin failures++; $display("FAIL reset_out got=%0d exp=0", out); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        rst_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%0b enable=%0b exp 0 0", busy, enable);
        end
    endtask

    task automatic test_loop_single();
        logic [WIDTH-1:0] got;
        ctrl = 1'b1;
        repeat (3) tick();
        run_window(2'd1, 0, 1'b0, got);
        checks++;
        if (got !== WIDTH'(15)) begin failures++; $display("FAIL loop_all_ones got=%0d exp=15", got); end
    endtask

    task automatic test_force_toggle();
        logic [WIDTH-1:0] got;
        run_window(2'd2, 1, 1'b0, got);
        checks++;
        if (got !== WIDTH'(8)) begin failures++; $display("FAIL force_toggle got=%0d exp=8", got); end
    endtask

    task automatic test_random_windows();
        logic [WIDTH-1:0] got;
        for (int it = 0; it < 8; it++) begin
            run_window(2'($urandom % 4), int'($urandom % 4), 1'($urandom % 2), got);
            repeat (int'($urandom % 3)) tick();
        end
    endtask

    // Continuous conversion: three windows with no gap, consumer always ready.
    task automatic test_back_to_back();
        int s, e, r0;
        logic ev;
        logic [WIDTH-1:0] ec;
        logic [1:0] m;
        m = 2'($urandom % 4);
        out_ready = 1'b1; mode = m; cont = 1'b1; start = 1'b1;
        ctrl = 1'($urandom % 2);
        tick();
        s = cyc - 1; r0 = s + LAT;
        start = 1'b0; cont = 1'b0;
        for (int i = 1; i <= LAT + 2 * N; i++) begin
            ctrl = 1'($urandom % 2);
            tick();
            e = cyc - 1;
            ev = (e >= r0) && (((e - r0) % N) == 0);
            checks++;
            if (out_valid !== ev) begin
                failures++;
                $display("FAIL b2b_valid edge=%0d got=%0b exp=%0b", e - s, out_valid, ev);
            end
            if (ev) begin
                ec = exp_code(e);
                checks++;
                if (out !== ec) begin
                    failures++;
                    $display("FAIL b2b_code edge=%0d got=%0d exp=%0d", e - s, out, ec);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_busy edge=%0d got=%0b exp=1", e - s, busy);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop got busy=%0b enable=%0b valid=%0b exp 0 0 0", busy, enable, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        int s;
        ctrl = 1'b0; out_ready = 1'b0; mode = 2'd1; cont = 1'b1; start = 1'b1;
        tick();
        s = cyc - 1;
        start = 1'b0; cont = 1'b0;
        while (cyc - 1 < s + LAT) tick();
        checks++;
        if (out_valid !== 1'b1 || out !== '0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_first got valid=%0b out=%0d ovr=%0b exp 1 0 0", out_valid, out, overrun);
        end
        while (cyc - 1 < s + LAT + N - 1) tick();
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%0b exp=0", overrun); end
        tick();
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out !== '0) begin
            failures++;
            $display("FAIL ovr_second got ovr=%0b valid=%0b out=%0d exp 1 1 0", overrun, out_valid, out);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_stop got busy=%0b valid=%0b ovr=%0b exp 0 1 1", busy, out_valid, overrun);
        end
        start = 1'b1; mode = 2'd0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ovr_clear got ovr=%0b busy=%0b exp 0 1", overrun, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovr_drain got valid=%0b busy=%0b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_stop();
        int s;
        mode = 2'd2; cont = 1'b0; out_ready = 1'b0; start = 1'b1;
        ctrl = 1'($urandom % 2);
        tick();
        s = cyc - 1;
        start = 1'b0;
        while (cyc - 1 < s + SETTLE_CYC + 6) begin
            ctrl = 1'($urandom % 2);
            tick();
        end
        checks++;
        if (busy !== 1'b1 || enable !== 1'b1) begin
            failures++;
            $display("FAIL stop_pre got busy=%0b enable=%0b exp 1 1", busy, enable);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle got busy=%0b enable=%0b exp 0 0", busy, enable);
        end
        for (int i = 0; i < N + 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL stop_no_result cyc=%0d got valid=%0b busy=%0b exp 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_start_stop();
        mode = 2'd2; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || enable !== 1'b0) begin
                failures++;
                $display("FAIL start_stop cyc=%0d got busy=%0b enable=%0b exp 0 0", i, busy, enable);
            end
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'd2; cont = 1'b1; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1 || enable !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got busy=%0b enable=%0b exp 1 1", busy, enable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (enable !== 1'b0 || out !== '0 || out_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid got en=%0b out=%0d valid=%0b ovr=%0b busy=%0b exp all 0",
                     enable, out, out_valid, overrun, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_loop_single();
        test_force_toggle();
        test_random_windows();
        test_back_to_back();
        test_overrun();
        test_stop();
        test_start_stop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
